mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch port and the data-memory port of the pipelined CPU.
- Sits between the datapath (fetch and memory stages) and the RAM model.
- Data requests get priority. A starvation counter guarantees fetch progress.
- Each transaction is held until the RAM reports ACCESS, then the result is returned with a one-cycle hit pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- MAX_DSTREAK, 4, max consecutive data grants while a fetch waits; range 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- ihit  out  1  one-cycle pulse, fetch complete.
- iload  out  DATA_W  fetched word; valid when ihit.
- dhit  out  1  one-cycle pulse, data op complete.
- dload  out  DATA_W  loaded word; valid when dhit.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- memerr  out  1  sticky; set on any ramstate==ERROR seen while granted.

Behaviour:
- Reset: state IDLE, dstreak=0, memerr=0. All outputs drive 0 while nRST low and in IDLE.
- FSM states: IDLE, IGNT, DGNT. The grant decision is registered; RAM signals assert from the first cycle in the grant state.
- IDLE -> DGNT: (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK).
- IDLE -> IGNT: iREN, and either no data request or the starvation condition holds.
- IDLE -> IDLE: no requests.
- IGNT:
  - Drives ramREN=1, ramaddr=iaddr, ramWEN=0.
  - On ramstate==ACCESS: ihit=1 and iload=ramload in that same cycle (combinational); next IDLE; dstreak<=0.
- DGNT:
  - If dWEN, drives ramWEN=1, ramREN=0. Otherwise drives ramREN=1. dWEN wins when both are high.
  - Drives ramaddr=daddr, ramstore=dstore.
  - On ACCESS: dhit=1, dload=ramload (0 for writes); next IDLE.
  - dstreak updates at completion: +1 if iREN high, saturating at MAX_DSTREAK; else 0.
- BUSY, FREE or ERROR in a grant state: stay, hits low. ERROR additionally sets memerr.
- Abort: if the granted requester deasserts its request before ACCESS, return to IDLE next cycle with no hit and dstreak unchanged. An aborted write may already have reached RAM; this is accepted.
- ihit and dhit are never high in the same cycle.
- At least one IDLE cycle separates consecutive transactions, giving 2-cycle minimum occupancy with a zero-wait RAM.
- Address and data inputs are sampled live; requesters must hold them stable while requesting.
- In IDLE, iload/dload/ramaddr/ramstore are 0.
- Asynchronous reset mid-transaction forces IDLE and zeroes all outputs immediately. No hit is produced.

Test Plan:
- Reset then iREN=1, iaddr=0x40, RAM returns ACCESS on the 2nd grant cycle with ramload=0x8C220004 -> ramREN high 2 cycles, ihit single pulse, iload=0x8C220004, back to IDLE.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, zero-wait RAM -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dhit pulse one cycle after grant; ramREN stays 0.
- iREN and dREN continuously high, MAX_DSTREAK=4, zero-wait RAM -> grant order D,D,D,D,I,D,D,D,D,I; dstreak returns to 0 after each I.
- dREN and dWEN both high -> write performed, ramREN=0, dload=0 at dhit.
- Fetch granted, ramstate BUSY 3 cycles then iREN drops -> IDLE next cycle, no ihit. A pending dREN is granted on the following cycle.
- ramstate=ERROR one cycle then ACCESS -> memerr set and held; hit still delivered. nRST pulse mid-DGNT -> all outputs 0 asynchronously, memerr cleared.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data; grant registered, RAM driven from first grant cycle, hit same cycle as ACCESS.
// Requests are held until hit (or dropped to abort); data has priority, bounded by a starvation streak for fetch.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              memerr
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t     state;
    logic [3:0] dstreak;

    logic dreq;
    logic starve;
    logic access;
    logic ram_err;

    assign dreq    = dREN | dWEN;
    assign starve  = iREN && (dstreak == STREAK_MAX);
    assign access  = (ramstate == RAM_ACCESS);
    assign ram_err = (ramstate == RAM_ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            dstreak <= 4'd0;
            memerr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && !starve)
                        state <= DGNT;
                    else if (iREN)
                        state <= IGNT;
                end
                IGNT: begin
                    if (ram_err)
                        memerr <= 1'b1;
                    // A dropped request aborts without touching the streak.
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (access) begin
                        state   <= IDLE;
                        dstreak <= 4'd0;
                    end
                end
                DGNT: begin
                    if (ram_err)
                        memerr <= 1'b1;
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (access) begin
                        state <= IDLE;
                        if (!iREN)
                            dstreak <= 4'd0;
                        else if (dstreak != STREAK_MAX)
                            dstreak <= dstreak + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                ihit    = iREN && access;
                if (iREN && access)
                    iload = ramload;
            end
            DGNT: begin
                // Write wins when both enables are high.
                ramWEN   = dWEN;
                ramREN   = !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dhit     = dreq && access;
                if (dreq && access && !dWEN)
                    dload = ramload;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramload(ramload), .ramstate(ramstate),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_i;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hits    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_i, input logic [31:0] data);
        exp_t e;
        e.is_i = is_i;
        e.data = data;
        sb.push_back(e);
    endtask

    // Mid-cycle sample: checks hit exclusivity and retires scoreboard entries on hits.
    task automatic to_neg();
        exp_t e;
        @(negedge CLK);
        chk("hit_exclusive", {31'b0, ihit & dhit}, 32'd0);
        if (ihit === 1'b1 || dhit === 1'b1) begin
            hits++;
            chk("sb_underflow", {31'b0, sb.size() == 0}, 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hit_kind", {31'b0, ihit}, {31'b0, e.is_i});
                chk("hit_data", ihit ? iload : dload, e.data);
            end
        end
    endtask

    task automatic to_next();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        to_neg();
        to_next();
    endtask

    initial begin
        int base;
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;

        // Reset state
        @(negedge CLK);
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_memerr", {31'b0, memerr}, 32'd0);
        chk("rst_hits", {30'b0, ihit, dhit}, 32'd0);
        nRST = 1'b1;
        to_next();

        // Fetch with one BUSY cycle then ACCESS
        iREN = 1; iaddr = 32'h40; ramload = 32'h8C220004; ramstate = BUSY;
        push(1'b1, 32'h8C220004);
        to_neg(); chk("t1_idle_ramREN", {31'b0, ramREN}, 32'd0); to_next();
        to_neg(); chk("t1_g1_ramREN", {31'b0, ramREN}, 32'd1);
        chk("t1_g1_ramaddr", ramaddr, 32'h40);
        chk("t1_g1_ihit", {31'b0, ihit}, 32'd0); to_next();
        ramstate = ACCESS;
        to_neg(); chk("t1_g2_ramREN", {31'b0, ramREN}, 32'd1);
        chk("t1_g2_ihit", {31'b0, ihit}, 32'd1); to_next();
        iREN = 0; ramstate = FREE;
        to_neg(); chk("t1_back_idle", {30'b0, ramREN, ihit}, 32'd0);
        chk("t1_iload_idle", iload, 32'd0); to_next();

        // Zero-wait write
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = ACCESS; ramload = 32'h12345678;
        push(1'b0, 32'd0);
        cyc();
        to_neg(); chk("t2_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("t2_ramREN", {31'b0, ramREN}, 32'd0);
        chk("t2_ramaddr", ramaddr, 32'h100);
        chk("t2_ramstore", ramstore, 32'hDEADBEEF);
        chk("t2_dhit", {31'b0, dhit}, 32'd1); to_next();
        dWEN = 0;
        to_neg(); chk("t2_idle", {29'b0, ramWEN, ramREN, dhit}, 32'd0);
        chk("t2_ramstore_idle", ramstore, 32'd0); to_next();

        // Starvation bound: both requesters always on, zero-wait RAM
        iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h204; ramload = 32'h0BADF00D;
        for (int k = 0; k < 10; k++)
            push((k == 4) || (k == 9), 32'h0BADF00D);
        base = hits;
        for (int c = 0; c < 60 && hits < base + 10; c++)
            cyc();
        iREN = 0; dREN = 0;
        chk("t3_hit_count", 32'(hits - base), 32'd10);
        chk("t3_sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        cyc();

        // Read+write together: write wins
        dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hCAFE0001; ramload = 32'h55555555; ramstate = ACCESS;
        push(1'b0, 32'd0);
        cyc();
        to_neg(); chk("t4_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("t4_ramREN", {31'b0, ramREN}, 32'd0);
        chk("t4_dload", dload, 32'd0); to_next();
        dREN = 0; dWEN = 0; ramstate = FREE;
        cyc();

        // Fetch abort after 3 BUSY cycles, pending data read then granted
        iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        cyc();
        dREN = 1; daddr = 32'h300;
        for (int c = 0; c < 3; c++) begin
            to_neg(); chk("t5_busy_ramREN", {31'b0, ramREN}, 32'd1);
            chk("t5_busy_ramaddr", ramaddr, 32'h80); to_next();
        end
        iREN = 0;
        to_neg(); chk("t5_abort_ihit", {31'b0, ihit}, 32'd0); to_next();
        to_neg(); chk("t5_idle_ramREN", {31'b0, ramREN}, 32'd0); to_next();
        ramstate = ACCESS; ramload = 32'h77;
        push(1'b0, 32'h77);
        to_neg(); chk("t5_dgnt_ramaddr", ramaddr, 32'h300);
        chk("t5_dgnt_dhit", {31'b0, dhit}, 32'd1); to_next();
        dREN = 0; ramstate = FREE;
        cyc();

        // ERROR then ACCESS
        dREN = 1; daddr = 32'h400; ramload = 32'hA5A5A5A5; ramstate = ERROR;
        to_neg(); chk("t6_idle_memerr", {31'b0, memerr}, 32'd0); to_next();
        to_neg(); chk("t6_err_dhit", {31'b0, dhit}, 32'd0);
        chk("t6_err_memerr", {31'b0, memerr}, 32'd0); to_next();
        ramstate = ACCESS;
        push(1'b0, 32'hA5A5A5A5);
        to_neg(); chk("t6_memerr_set", {31'b0, memerr}, 32'd1);
        chk("t6_dhit", {31'b0, dhit}, 32'd1); to_next();
        dREN = 0; ramstate = FREE;
        to_neg(); chk("t6_memerr_held", {31'b0, memerr}, 32'd1); to_next();

        // Asynchronous reset mid-DGNT
        dWEN = 1; daddr = 32'h500; dstore = 32'h11; ramstate = BUSY;
        cyc();
        to_neg(); chk("t7_dgnt_ramWEN", {31'b0, ramWEN}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("t7_rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("t7_rst_ramaddr", ramaddr, 32'd0);
        chk("t7_rst_ramstore", ramstore, 32'd0);
        chk("t7_rst_memerr", {31'b0, memerr}, 32'd0);
        chk("t7_rst_dhit", {31'b0, dhit}, 32'd0);
        dWEN = 0;
        @(negedge CLK);
        nRST = 1'b1;
        to_next();
        cyc();
        to_neg(); chk("t7_after_idle", {30'b0, ramWEN, ramREN}, 32'd0); to_next();
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
